// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial unsigned adder, one full-adder cell, LSB first
//
// Purpose: adds two WIDTH-bit unsigned operands one bit per clock using a
// single full-adder cell with a registered carry. The operation is started
// by a start/busy/done handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only in IDLE
//   a, b       addends, captured on the accepted start edge
//   busy       high in RUN and DONE
//   done       one-cycle pulse; sum/carry_out valid from this cycle
//   sum        (a+b) mod 2^WIDTH, held until the next completed operation
//   carry_out  carry out of the MSB
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic s_bit;
  logic c_next;
  logic last_bit;

  // Full-adder bit cell on the current LSBs and the registered carry.
  assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit = (cnt == LAST);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // The A shift register doubles as the result register: each sum bit enters
  // at the MSB end as the consumed A bit leaves the LSB end, so after WIDTH
  // shifts it holds the full sum with no extra storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sr  <= {s_bit, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= c_next;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum       <= {s_bit, a_sr[WIDTH-1:1]};
            carry_out <= c_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH 8 and 4)
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, sum8;
  logic [3:0] a4, b4, sum4;
  logic       busy8, done8, co8;
  logic       busy4, done4, co4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_co;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one WIDTH=8 operation from IDLE and waits for done (bounded).
  // lat counts clock edges after the start edge until done is seen.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output int lat, output int bcnt,
                     output logic [7:0] s, output logic c);
    int k;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b;
    k = 0; bcnt = 0;
    while (!done8 && k < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      k++;
    end
    if (busy8) bcnt++;
    lat = k;
    s = sum8; c = co8;
    if (!done8) chk("op8_timeout", 0, 1);
    @(negedge clk);
    chk("op8_done_one_cycle", {62'd0, done8, busy8}, 64'd0);
  endtask

  initial begin
    int lat, bcnt, ndone, busy_after, first_done, prev_done, gaps_ok;
    logic [7:0] s;
    logic c;
    logic [8:0] ref9;
    logic [4:0] ref5;
    logic [7:0] ra, rb;

    vecs[0] = '{8'h25, 8'h1A, 8'h3F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 8'hFF, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0};

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {52'd0, busy8, done8, co8, sum8, busy4}, 64'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      op8(vecs[i].a, vecs[i].b, lat, bcnt, s, c);
      chk($sformatf("vec%0d_sum", i), {55'd0, c, s}, {55'd0, vecs[i].exp_co, vecs[i].exp_sum});
      chk($sformatf("vec%0d_latency", i), lat, 8);
      if (i == 0) chk("vec0_busy_cycles", bcnt, 9);
    end

    // Random operands against plain integer addition.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8(ra, rb, lat, bcnt, s, c);
      ref9 = {1'b0, ra} + {1'b0, rb};
      chk($sformatf("rand%0d_%0h_%0h", i, ra, rb), {55'd0, c, s}, {55'd0, ref9});
    end

    // Operand change and extra start while RUN must be ignored.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0; busy_after = 0; s = 8'hxx; c = 1'bx;
    for (int k = 0; k < 25; k++) begin
      if (ndone > 0 && busy8 && !done8) busy_after++;
      if (done8) begin
        ndone++; s = sum8; c = co8;
      end
      @(negedge clk);
    end
    chk("ignored_start_done_count", ndone, 1);
    chk("ignored_start_result", {55'd0, c, s}, {55'd0, 1'b1, 8'h00});
    chk("ignored_start_no_second_op", busy_after, 0);

    // Reset at edge E4 aborts the operation.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_outputs", {55'd0, busy8, co8, sum8}, 64'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    chk("midreset_no_done", ndone, 0);

    // Back-to-back with start held high.
    a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
    ndone = 0; first_done = -1; prev_done = -1; gaps_ok = 1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        chk($sformatf("b2b_result%0d", ndone), {55'd0, co8, sum8}, {55'd0, 1'b0, 8'h10});
        if (prev_done >= 0 && k - prev_done != 10) gaps_ok = 0;
        if (first_done < 0) first_done = k;
        prev_done = k;
      end
    end
    start8 = 1'b0;
    chk("b2b_first_latency", first_done, 8);
    chk("b2b_pulse_count", ndone, 4);
    chk("b2b_period_10", gaps_ok, 1);
    repeat (12) @(negedge clk);

    // Exhaustive WIDTH=4.
    begin
      int bad4 = 0;
      int pulse_bad = 0;
      for (int i = 0; i < 256; i++) begin
        int k;
        @(negedge clk);
        a4 = 4'(i >> 4); b4 = 4'(i); start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        k = 0;
        while (!done4 && k < 20) begin
          @(negedge clk);
          k++;
        end
        ref5 = 5'(i >> 4) + 5'(i & 15);
        if ({co4, sum4} !== ref5 || k != 4) begin
          bad4++;
          if (bad4 < 5) $display("w4 pair a=%0h b=%0h got %0h expected %0h lat %0d", i >> 4, i & 15, {co4, sum4}, ref5, k);
        end
        @(negedge clk);
        if (done4 !== 1'b0) pulse_bad++;
      end
      chk("w4_exhaustive_bad_pairs", bad4, 0);
      chk("w4_done_width_bad", pulse_bad, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial unsigned adder: the addition counterpart of the team's subtractor cells.
- Built around a single full-adder bit cell with a registered carry.
- Processes one operand bit per clock, LSB first, under a start/busy/done handshake.
- Serves as the area-minimal add path for wide operands where a ripple or parallel adder is too costly.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  addend A; captured on the accepted start edge.
- b  input  WIDTH  addend B; captured on the accepted start edge.
- busy  output  1  high while an operation is in flight (RUN or DONE).
- done  output  1  single-cycle pulse; sum and carry_out are valid from this cycle.
- sum  output  WIDTH  (A+B) mod 2^WIDTH.
- carry_out  output  1  carry out of the MSB.

Behaviour:
- Reset: synchronous, active-high. Applies on any rising edge with rst=1, in any state, including mid-operation. All of the following clear to 0:
  - state→IDLE
  - busy, done
  - sum, carry_out
  - internal shift registers, carry register and bit counter
- Reset overrides start on the same edge.
- An operation aborted by reset never pulses done.
- States:
  - IDLE: busy=0, done=0.
    - Edge with start=1 → latch a and b into shift registers.
    - Clear the carry register and the bit counter; go to RUN.
    - start=0 → stay in IDLE.
  - RUN: busy=1, done=0. Each edge:
    - bit cell: s = a_sr[0]^b_sr[0]^c; c_next = majority(a_sr[0], b_sr[0], c).
    - s shifts into the result register from the MSB end.
    - a_sr and b_sr shift right by one; the counter increments.
    - On the edge that processes bit WIDTH-1:
      - load sum from the completed result register.
      - load carry_out from c_next.
      - go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle. Next edge → IDLE unconditionally.
- Latency: the start edge is E0; done is high in the cycle following edge E(WIDTH). Throughput is one result per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored and is not queued.
- start in the first IDLE cycle after DONE is accepted, so back-to-back operations are allowed.
- a and b may change freely after the start edge without affecting the result.
- sum and carry_out hold their last completed value through IDLE and the next RUN. They update only on the DONE transition.
- Arithmetic:
  - unsigned, modulo 2^WIDTH, with carry_out = bit WIDTH of the true sum.
  - {carry_out, sum} == a + b for all inputs.
- Counter width is $clog2(WIDTH). There is no wrap-around beyond WIDTH-1 because RUN exits at count WIDTH-1.
- No X propagation after the first reset. Before the first reset, outputs are undefined.

Test Plan:
- WIDTH=8: reset, then start with a=8'h25, b=8'h1A.
  - done rises exactly 8 edges after the start edge.
  - sum=8'h3F, carry_out=0, busy high for 9 cycles.
- Full-carry propagation:
  - a=8'hFF, b=8'h01 → sum=8'h00, carry_out=1.
  - a=8'hFF, b=8'hFF → sum=8'hFE, carry_out=1.
  - a=8'h00, b=8'h00 → sum=8'h00, carry_out=0.
- Input stability and ignored start:
  - Start with a=8'h80, b=8'h80.
  - Change a and b to 8'h01 on the next cycle and pulse start again during RUN.
  - Required: exactly one done pulse, sum=8'h00, carry_out=1.
  - Required: no second operation begins until start is reasserted in IDLE.
- Reset mid-operation:
  - Start a=8'h12, b=8'h34; assert rst for one cycle at edge E4.
  - Required: busy=0, sum=0, carry_out=0 the cycle after.
  - Required: no done pulse within the following 12 cycles.
- Back-to-back operations:
  - Start a=8'h0F, b=8'h01; hold start high continuously.
  - Required: first done gives sum=8'h10, carry_out=0.
  - Required: the next operation is accepted in the IDLE cycle after DONE.
  - Required: done pulses again every 10 cycles with identical results.
- Exhaustive check at WIDTH=4:
  - Run all 256 a/b pairs.
  - Required: {carry_out, sum} == a+b for every pair.
  - Required: done is high for exactly 1 cycle per operation.
